toggle_hs_receiver: RTL and testbench
=====================================

TOGGLE_HS_RECEIVER -- requirements
Module: toggle_hs_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, receive buffer entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port req_tgl, input, 1, two-phase request; every level change announces one new word.
REQ-006 SHALL have port data_in, input, DATA_W, payload; sender holds it stable from a req_tgl change until the matching ack_tgl change.
REQ-007 SHALL have port ack_tgl, output, 1, two-phase acknowledge; toggles once per accepted word.
REQ-008 SHALL have port out_valid, output, 1, buffer non-empty.
REQ-009 SHALL have port out_data, output, DATA_W, head-of-buffer word; valid only while out_valid=1.
REQ-010 SHALL have port out_ready, input, 1, consumer pops the head when out_valid and out_ready are both 1 at posedge clk.
REQ-011 SHALL have port xfer_count, output, 16, total accepted words; wraps from 0xFFFF to 0x0000.
REQ-012 SHALL have port stall, output, 1, high while a request is pending and the buffer is full.

Function
REQ-013 SHALL pass req_tgl through a 2-flop synchronizer (req_s1, req_s2) before any use; data_in is not synchronized.
REQ-014 SHALL keep req_seen, the last accepted request level; a request is pending when req_s2 != req_seen.
REQ-015 SHALL implement FSM IDLE/STALL: IDLE with a pending request and buffer not full -> accept, stay IDLE; IDLE with a pending request and buffer full -> STALL; STALL -> IDLE on the cycle the word is accepted.
REQ-016 SHALL define accept as: pending request, and buffer not full or a pop in the same cycle; on accept, write data_in to the tail, set req_seen to req_s2, toggle ack_tgl, and increment xfer_count, all registered in that cycle.
REQ-017 SHALL produce ack_tgl from a flop that toggles only on accept, never glitching.
REQ-018 SHALL give latency from a req_tgl change to an ack_tgl change of exactly 3 clk edges when the buffer is not full: 2 synchronizer edges plus 1 accept edge.
REQ-019 SHALL accept at most one word per request toggle; toggles that occur before the matching ack are a protocol violation with undefined payload, but the FSM SHALL still resynchronize on req_s2.
REQ-020 SHALL implement a circular buffer with wrapping read/write pointers and an occupancy count of width clog2(DEPTH)+1; full when count=DEPTH, empty when count=0.
REQ-021 SHALL keep the count unchanged on a simultaneous push and pop, including when full (pop frees the slot the push uses) and when empty with out_valid=0 (no pop occurs, so the push alone increments).
REQ-022 SHALL ignore out_ready while empty and SHALL not alter the pointers.
REQ-023 SHALL drive out_data from the read pointer, first-word-fall-through, with out_valid asserting the cycle after the first push.
REQ-024 SHALL drive stall = (state==STALL), registered.

Reset
REQ-025 SHALL, while rst=1, force req_s1=0, req_s2=0, req_seen=0, ack_tgl=0, pointers=0, count=0, xfer_count=0, state=IDLE, out_valid=0, stall=0; out_data is don't-care.
REQ-026 SHALL, on reset mid-transfer, discard buffered and pending words; after release, a req_tgl level of 1 is treated as pending against req_seen=0, and the sender must also reset to keep the phases aligned.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, STALL) and the XFER_CNT_W=16 constant in shared package hs_pkg.
REQ-028 SHALL instantiate a single sub-module sync_2ff for the request synchronizer; the buffer and FSM stay inline.

Verification
REQ-029 SHALL cover single transfer: after reset, data_in=0xA5 and req_tgl 0->1 -> ack_tgl 0->1 on the 3rd edge, out_valid=1, out_data=0xA5, xfer_count=1.
REQ-030 SHALL cover fill: with out_ready=0, send 5 words 0x01..0x05 (DEPTH=4) -> 4 acks, then stall=1 with no 5th ack; raise out_ready for 1 cycle -> 5th ack, pop 0x01, count stays 4.
REQ-031 SHALL cover simultaneous push/pop while full -> count stays 4, output order 0x02,0x03,0x04,0x05.
REQ-032 SHALL cover counter wrap: preload 0xFFFF transfers through stimulus, send 1 more -> xfer_count=0x0000.
REQ-033 SHALL cover reset mid-operation: 2 words buffered plus 1 pending, assert rst asynchronously between edges -> all outputs reach reset values immediately; out_valid=0 after release.
REQ-034 SHALL cover back-to-back: sender toggles again immediately on each ack, 8 words -> all 8 received in order, one ack per word, never more.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and constants for the two-phase handshake receiver.
package hs_pkg;

  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s1,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1 = s1_q;
  assign q  = s2_q;

endmodule

// File: rtl/toggle_hs_receiver.sv
// Two-phase (toggle) request/acknowledge receiver feeding a small FWFT circular buffer.
module toggle_hs_receiver
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_tgl,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  ack_tgl,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  stall
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic req_s1, req_s2;

  sync_2ff u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_tgl),
    .s1  (req_s1),
    .q   (req_s2)
  );

  logic                  req_seen_q, req_seen_d;
  logic                  ack_q, ack_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [XFER_CNT_W-1:0] xfer_q, xfer_d;
  logic                  valid_q, valid_d;
  logic                  stall_q, stall_d;
  rx_state_e             state_q, state_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic pending, full, pop, accept;

  always_comb begin
    pending = (req_s2 != req_seen_q);
    full    = (count_q == CNT_W'(DEPTH));
    pop     = valid_q && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    accept  = pending && (!full || pop);

    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    xfer_d     = xfer_q;
    state_d    = state_q;

    if (accept) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      req_seen_d = req_s2;
      ack_d      = ~ack_q;
      xfer_d     = xfer_q + XFER_CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    if (pending && !accept) state_d = STALL;
      // Leaving on a vanished request keeps the FSM aligned after a protocol violation.
      STALL:   if (accept || !pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (count_d != '0);
    stall_d = (state_d == STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_q     <= '0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_q     <= xfer_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_in;
  end

  logic unused_s1;
  assign unused_s1 = req_s1;

  assign ack_tgl    = ack_q;
  assign out_valid  = valid_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign xfer_count = xfer_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed bench for toggle_hs_receiver: vector table plus multi-cycle sequences.
module tb_toggle_hs_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_tgl = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        out_ready = 1'b0;
  logic        ack_tgl;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] xfer_count;
  logic        stall;

  toggle_hs_receiver #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tgl    (req_tgl),
    .data_in    (data_in),
    .ack_tgl    (ack_tgl),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .xfer_count (xfer_count),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic want, input string name, output int edges);
    edges = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack_tgl === want) begin
        edges = c;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: ack timeout got %0b expected %0b", name, ack_tgl, want);
  endtask

  task automatic send_word(input logic [7:0] d, input string name);
    int e;
    data_in = d;
    req_tgl = ~req_tgl;
    exp_ack = ~exp_ack;
    wait_ack(exp_ack, name, e);
    check({name, ".latency"}, e, 3);
  endtask

  // Negedge monitor of pops and ack edges for the back-to-back sequence.
  logic [7:0] rx_q[$];
  int         ack_changes = 0;
  bit         mon_en = 1'b0;
  logic       ack_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (ack_tgl !== ack_prev) ack_changes++;
    end
    ack_prev = ack_tgl;
  end

  typedef struct {
    bit          tgl;
    logic [7:0]  data;
    bit          rdy;
    int          n;
    bit          ack;
    bit          valid;
    logic [7:0]  odata;
    logic [15:0] xfer;
    bit          stall;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          tgl data   rdy n  ack val odata  xfer    stall
    vecs[0]  = '{0, 8'h00, 0, 0, 0, 0, 8'h00, 16'd0, 0};
    vecs[1]  = '{1, 8'hA5, 0, 2, 0, 0, 8'h00, 16'd0, 0};
    vecs[2]  = '{0, 8'hA5, 0, 1, 1, 1, 8'hA5, 16'd1, 0};
    vecs[3]  = '{0, 8'hA5, 1, 1, 1, 0, 8'h00, 16'd1, 0};
    vecs[4]  = '{1, 8'h01, 0, 3, 0, 1, 8'h01, 16'd2, 0};
    vecs[5]  = '{1, 8'h02, 0, 3, 1, 1, 8'h01, 16'd3, 0};
    vecs[6]  = '{1, 8'h03, 0, 3, 0, 1, 8'h01, 16'd4, 0};
    vecs[7]  = '{1, 8'h04, 0, 3, 1, 1, 8'h01, 16'd5, 0};
    vecs[8]  = '{1, 8'h05, 0, 3, 1, 1, 8'h01, 16'd5, 1};
    vecs[9]  = '{0, 8'h05, 0, 2, 1, 1, 8'h01, 16'd5, 1};
    vecs[10] = '{0, 8'h05, 1, 1, 0, 1, 8'h02, 16'd6, 0};
    vecs[11] = '{0, 8'h05, 1, 1, 0, 1, 8'h03, 16'd6, 0};
    vecs[12] = '{0, 8'h05, 1, 1, 0, 1, 8'h04, 16'd6, 0};
    vecs[13] = '{0, 8'h05, 1, 1, 0, 1, 8'h05, 16'd6, 0};
    vecs[14] = '{0, 8'h05, 1, 1, 0, 0, 8'h00, 16'd6, 0};
    vecs[15] = '{0, 8'h05, 1, 2, 0, 0, 8'h00, 16'd6, 0};

    repeat (3) tick();
    rst = 1'b0;

    // Single transfer, fill/stall, push+pop while full, drain, ready while empty.
    for (int i = 0; i < 16; i++) begin
      data_in   = vecs[i].data;
      out_ready = vecs[i].rdy;
      if (vecs[i].tgl) req_tgl = ~req_tgl;
      repeat (vecs[i].n) tick();
      check($sformatf("v%0d.ack", i), ack_tgl, vecs[i].ack);
      check($sformatf("v%0d.valid", i), out_valid, vecs[i].valid);
      if (vecs[i].valid) check($sformatf("v%0d.data", i), out_data, vecs[i].odata);
      check($sformatf("v%0d.xfer", i), xfer_count, vecs[i].xfer);
      check($sformatf("v%0d.stall", i), stall, vecs[i].stall);
    end
    exp_ack = 1'b0;

    // Back-to-back: sender re-toggles as soon as each ack is seen.
    rx_q.delete();
    ack_changes = 0;
    out_ready   = 1'b1;
    mon_en      = 1'b1;
    for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i), $sformatf("b2b%0d", i));
    repeat (4) tick();
    mon_en = 1'b0;
    check("b2b.count", rx_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rx_q.size()) check($sformatf("b2b.word%0d", i), rx_q[i], 8'h10 + 8'(i));
    check("b2b.acks", ack_changes, 8);
    check("b2b.xfer", xfer_count, 16'd14);

    // Counter wrap: one toggle per cycle is accepted once per cycle.
    for (int i = 0; i < 65521; i++) begin
      req_tgl = ~req_tgl;
      tick();
    end
    repeat (5) tick();
    exp_ack = ~exp_ack;
    check("wrap.pre_xfer", xfer_count, 16'hFFFF);
    check("wrap.pre_ack", ack_tgl, exp_ack);
    check("wrap.pre_stall", stall, 1'b0);
    check("wrap.pre_valid", out_valid, 1'b0);
    send_word(8'h77, "wrap");
    check("wrap.xfer", xfer_count, 16'h0000);
    check("wrap.data", out_data, 8'h77);

    // Reset mid-operation with words buffered and one request in flight.
    tick();
    out_ready = 1'b0;
    send_word(8'hC1, "rst_w1");
    send_word(8'hC2, "rst_w2");
    data_in = 8'hC3;
    req_tgl = ~req_tgl;
    tick();
    check("rst.pre_valid", out_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rst.ack", ack_tgl, 1'b0);
    check("rst.valid", out_valid, 1'b0);
    check("rst.xfer", xfer_count, 16'd0);
    check("rst.stall", stall, 1'b0);
    req_tgl = 1'b0;
    exp_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rst.post_valid", out_valid, 1'b0);
    check("rst.post_ack", ack_tgl, 1'b0);
    check("rst.post_xfer", xfer_count, 16'd0);
    send_word(8'h3C, "rst_after");
    check("rst_after.valid", out_valid, 1'b1);
    check("rst_after.data", out_data, 8'h3C);
    check("rst_after.xfer", xfer_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
